fetch_pc: RTL and testbench

FETCH_PC -- requirements
Module: fetch_pc

---
 rtl/fetch_pc.sv | 128 ++++++++++++
 tb/tb_fetch_pc.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc.sv
// fetch_pc: single-outstanding instruction fetch sequencer with jump redirect,
// flush of in-flight requests and a saturating squash counter.
`default_nettype none

module fetch_pc #(
   parameter logic [7:0] RESET_PC = 8'h00,
   parameter int          IW       = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall,
   input  logic          jump_valid,
   input  logic [7:0]    jump_target,
   output logic          jump_ready,
   output logic          imem_req,
   output logic [7:0]    imem_addr,
   input  logic          imem_ack,
   input  logic [IW-1:0] imem_data,
   output logic          instr_valid,
   input  logic          instr_ready,
   output logic [IW-1:0] instr,
   output logic [7:0]    instr_pc,
   output logic [7:0]    pc,
   output logic [7:0]    squash_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      FLUSH = 2'd3
   } state_t;

   state_t        state_q;
   logic [7:0]    pc_q;
   logic [7:0]    addr_q;
   logic          req_q;
   logic          valid_q;
   logic [IW-1:0] instr_q;
   logic [7:0]    instr_pc_q;
   logic [7:0]    squash_q;
   logic [7:0]    squash_inc;
   logic          jump_take;

   // Gated by rst so a jump offered during reset is never handshaken.
   assign jump_ready = ~rst & (state_q != FLUSH);
   assign jump_take  = jump_valid & jump_ready;
   assign squash_inc = (squash_q == 8'hFF) ? squash_q : squash_q + 8'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         addr_q     <= RESET_PC;
         req_q      <= 1'b0;
         valid_q    <= 1'b0;
         instr_q    <= '0;
         instr_pc_q <= 8'h00;
         squash_q   <= 8'h00;
      end else begin
         case (state_q)
            IDLE: begin
               if (jump_take) begin
                  pc_q    <= jump_target;
                  valid_q <= 1'b0;
               end else if (!stall) begin
                  state_q <= FETCH;
                  req_q   <= 1'b1;
                  addr_q  <= pc_q;
               end
            end
            FETCH: begin
               if (jump_take) begin
                  pc_q    <= jump_target;
                  valid_q <= 1'b0;
                  if (imem_ack) begin
                     squash_q <= squash_inc;
                     req_q    <= 1'b0;
                     state_q  <= IDLE;
                  end else begin
                     // Request already issued: keep it on the bus until acked.
                     state_q <= FLUSH;
                  end
               end else if (imem_ack) begin
                  instr_q    <= imem_data;
                  instr_pc_q <= pc_q;
                  pc_q       <= pc_q + 8'd1;
                  valid_q    <= 1'b1;
                  req_q      <= 1'b0;
                  state_q    <= HOLD;
               end
            end
            HOLD: begin
               if (jump_take) begin
                  pc_q    <= jump_target;
                  valid_q <= 1'b0;
                  state_q <= IDLE;
               end else if (instr_ready) begin
                  valid_q <= 1'b0;
                  state_q <= IDLE;
               end
            end
            FLUSH: begin
               if (imem_ack) begin
                  squash_q <= squash_inc;
                  req_q    <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = addr_q;
   assign instr_valid = valid_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign pc          = pc_q;
   assign squash_cnt  = squash_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc.sv
// tb_fetch_pc: directed self-checking bench for fetch_pc.
`default_nettype none
`timescale 1ns/1ps

module tb_fetch_pc;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        jump_valid;
   logic [7:0]  jump_target;
   logic        jump_ready;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack;
   logic [15:0] imem_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic [7:0]  instr_pc;
   logic [7:0]  pc;
   logic [7:0]  squash_cnt;

   int n_checks;
   int n_errors;
   int n;

   fetch_pc #(
      .RESET_PC (8'h00),
      .IW       (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .jump_valid  (jump_valid),
      .jump_target (jump_target),
      .jump_ready  (jump_ready),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_data   (imem_data),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .pc          (pc),
      .squash_cnt  (squash_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      rst         = 1'b1;
      stall       = 1'b0;
      jump_valid  = 1'b0;
      jump_target = 8'h00;
      imem_ack    = 1'b0;
      imem_data   = 16'h0000;
      instr_ready = 1'b1;

      // Reset values
      repeat (3) step();
      check("rst_req",    32'(imem_req),    0);
      check("rst_addr",   32'(imem_addr),   32'h00);
      check("rst_valid",  32'(instr_valid), 0);
      check("rst_instr",  32'(instr),       0);
      check("rst_ipc",    32'(instr_pc),    0);
      check("rst_pc",     32'(pc),          32'h00);
      check("rst_squash", 32'(squash_cnt),  0);
      check("rst_jr",     32'(jump_ready),  0);

      rst = 1'b0;
      #1;
      check("idle_jr",  32'(jump_ready), 1);
      check("idle_req", 32'(imem_req),   0);

      // Sequential fetches 00,01,02
      for (int k = 0; k < 3; k++) begin
         n = 0;
         while (!imem_req && n < 4) begin
            step();
            n++;
         end
         check("req_seen", 32'(imem_req), 1);
         if (k == 0) check("first_req_by_edge2", 32'(n <= 2), 1);
         check("seq_addr", 32'(imem_addr), 32'(k));
         check("fetch_jr", 32'(jump_ready), 1);
         imem_ack  = 1'b1;
         imem_data = 16'hA000 + 16'(k);
         step();
         imem_ack  = 1'b0;
         check("seq_valid", 32'(instr_valid), 1);
         check("seq_instr", 32'(instr),       32'hA000 + 32'(k));
         check("seq_ipc",   32'(instr_pc),    32'(k));
         check("seq_pc",    32'(pc),          32'(k + 1));
      end

      // Stall holds IDLE, then jump to FF and wrap
      step();
      stall = 1'b1;
      check("hold_exit_valid", 32'(instr_valid), 0);
      repeat (3) step();
      check("stall_req", 32'(imem_req), 0);
      jump_valid  = 1'b1;
      jump_target = 8'hFF;
      step();
      jump_valid = 1'b0;
      stall      = 1'b0;
      check("jmp_idle_pc", 32'(pc), 32'hFF);
      step();
      check("ff_req",  32'(imem_req),  1);
      check("ff_addr", 32'(imem_addr), 32'hFF);
      imem_ack  = 1'b1;
      imem_data = 16'hBEEF;
      step();
      imem_ack = 1'b0;
      check("ff_ipc",   32'(instr_pc), 32'hFF);
      check("ff_instr", 32'(instr),    32'hBEEF);
      check("ff_pc",    32'(pc),       32'h00);
      step();
      step();
      check("wrap_addr", 32'(imem_addr), 32'h00);

      // Jump in FETCH without ack -> FLUSH; jumps ignored while flushing
      jump_valid  = 1'b1;
      jump_target = 8'h40;
      step();
      jump_target = 8'h77;
      check("flush_jr",    32'(jump_ready),  0);
      check("flush_req",   32'(imem_req),    1);
      check("flush_addr",  32'(imem_addr),   32'h00);
      check("flush_valid", 32'(instr_valid), 0);
      step();
      step();
      check("flush_hold_jr", 32'(jump_ready), 0);
      imem_ack = 1'b1;
      step();
      imem_ack   = 1'b0;
      jump_valid = 1'b0;
      check("flush_squash", 32'(squash_cnt),  1);
      check("flush_pc",     32'(pc),          32'h40);
      check("flush_done_req", 32'(imem_req),  0);
      check("flush_done_valid", 32'(instr_valid), 0);
      step();
      check("redir40_req",  32'(imem_req),  1);
      check("redir40_addr", 32'(imem_addr), 32'h40);

      // Jump with ack in the same cycle: data dropped, 2-cycle redirect
      jump_valid  = 1'b1;
      jump_target = 8'h20;
      imem_ack    = 1'b1;
      imem_data   = 16'hDEAD;
      step();
      jump_valid = 1'b0;
      imem_ack   = 1'b0;
      check("same_squash", 32'(squash_cnt),  2);
      check("same_valid",  32'(instr_valid), 0);
      check("same_req",    32'(imem_req),    0);
      step();
      check("redir20_req",  32'(imem_req),  1);
      check("redir20_addr", 32'(imem_addr), 32'h20);

      // HOLD with decode back-pressure, then jump away
      instr_ready = 1'b0;
      imem_ack    = 1'b1;
      imem_data   = 16'h1234;
      step();
      imem_ack = 1'b0;
      check("hold_valid", 32'(instr_valid), 1);
      check("hold_ipc",   32'(instr_pc),    32'h20);
      check("hold_pc",    32'(pc),          32'h21);
      for (int i = 0; i < 4; i++) begin
         step();
         check("hold_instr", 32'(instr),       32'h1234);
         check("hold_vld",   32'(instr_valid), 1);
      end
      jump_valid  = 1'b1;
      jump_target = 8'h10;
      step();
      jump_valid  = 1'b0;
      instr_ready = 1'b1;
      check("hjmp_valid",  32'(instr_valid), 0);
      check("hjmp_pc",     32'(pc),          32'h10);
      check("hjmp_squash", 32'(squash_cnt),  2);
      step();
      check("redir10_req",  32'(imem_req),  1);
      check("redir10_addr", 32'(imem_addr), 32'h10);

      // Squash counter saturation
      for (int i = 0; i < 260; i++) begin
         jump_valid  = 1'b1;
         jump_target = 8'h10;
         imem_ack    = 1'b1;
         step();
         jump_valid = 1'b0;
         imem_ack   = 1'b0;
         step();
      end
      check("squash_sat", 32'(squash_cnt), 32'hFF);

      // Reset in the middle of FLUSH, late ack ignored
      jump_valid  = 1'b1;
      jump_target = 8'h55;
      step();
      jump_valid = 1'b0;
      check("pre_rst_jr", 32'(jump_ready), 0);
      #2;
      rst = 1'b1;
      #1;
      check("arst_req",    32'(imem_req),    0);
      check("arst_addr",   32'(imem_addr),   32'h00);
      check("arst_pc",     32'(pc),          32'h00);
      check("arst_squash", 32'(squash_cnt),  0);
      check("arst_jr",     32'(jump_ready),  0);
      check("arst_valid",  32'(instr_valid), 0);
      step();
      step();
      rst       = 1'b0;
      stall     = 1'b1;
      imem_ack  = 1'b1;
      imem_data = 16'hFFFF;
      step();
      step();
      check("late_ack_squash", 32'(squash_cnt),  0);
      check("late_ack_valid",  32'(instr_valid), 0);
      check("late_ack_req",    32'(imem_req),    0);
      imem_ack = 1'b0;
      stall    = 1'b0;
      step();
      check("post_rst_req",    32'(imem_req),   1);
      check("post_rst_addr",   32'(imem_addr),  32'h00);
      check("post_rst_squash", 32'(squash_cnt), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
